// File: rtl/commit_rat.sv
// Committed register alias table: tracks each architectural register's committed physical tag and recycles superseded tags.
// Latency: commits visible in the table and freed tags visible on the free ports one cycle later; lookup is registered (1 cycle).
// Backpressure: OUT_stall asserts when the free-tag FIFO cannot absorb a full commit bundle; free ports use valid/ready, prefix-contiguous.
module commit_rat #(
  parameter int WIDTH      = 4,
  parameter int NUM_AREGS  = 32,
  parameter int TAG_LEN    = 7,
  parameter int FREE_DEPTH = 16,
  parameter int FREE_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              IN_comValid,
  input  logic [WIDTH*5-1:0]            IN_comRd,
  input  logic [WIDTH*TAG_LEN-1:0]      IN_comTag,
  input  logic                          IN_flush,
  output logic                          OUT_stall,
  output logic [FREE_PORTS-1:0]         OUT_freeValid,
  output logic [FREE_PORTS*TAG_LEN-1:0] OUT_freeTag,
  input  logic [FREE_PORTS-1:0]         IN_freeReady,
  input  logic [4:0]                    IN_lookupRd,
  output logic [TAG_LEN-1:0]            OUT_lookupTag,
  output logic                          OUT_overflow
);

  localparam int PTR_W  = $clog2(FREE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // One extra bit so count + pushes never wraps before the capacity compare.
  localparam int SUM_W  = CNT_W + 1;
  localparam int PIDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TAG_LEN-1:0] NO_TAG = {1'b1, {(TAG_LEN-1){1'b0}}};

  typedef logic [TAG_LEN-1:0] tag_t;

  // Architectural state
  tag_t             crat_q [NUM_AREGS];
  tag_t             crat_d [NUM_AREGS];
  tag_t             lookup_q;
  logic             overflow_q;
  logic             overflow_d;

  // Free-tag FIFO state
  tag_t             mem_q [FREE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Per-cycle commit results
  tag_t             push_tag [WIDTH];
  logic [SUM_W-1:0] n_push;
  logic [SUM_W-1:0] n_pop;
  logic [SUM_W-1:0] n_accept;
  logic [SUM_W-1:0] room;
  logic [4:0]       slot_rd;
  tag_t             slot_tag;
  tag_t             slot_old;

  // Walk the commit slots oldest-first against a working copy of the table so
  // same-cycle writes to one register chain correctly and the youngest wins.
  always_comb begin
    for (int a = 0; a < NUM_AREGS; a++) begin
      crat_d[a] = crat_q[a];
    end
    for (int k = 0; k < WIDTH; k++) begin
      push_tag[k] = '0;
    end
    n_push   = '0;
    slot_rd  = '0;
    slot_tag = '0;
    slot_old = '0;
    if (!IN_flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (IN_comValid[i]) begin
          slot_rd  = IN_comRd[i*5 +: 5];
          slot_tag = IN_comTag[i*TAG_LEN +: TAG_LEN];
          if (slot_rd != 5'd0) begin
            slot_old        = crat_d[slot_rd];
            crat_d[slot_rd] = slot_tag;
            if (!slot_old[TAG_LEN-1]) begin
              push_tag[n_push[PIDX_W-1:0]] = slot_old;
              n_push = n_push + SUM_W'(1);
            end
          end else if (!slot_tag[TAG_LEN-1]) begin
            // x0 never takes a mapping; the allocated tag goes straight back.
            push_tag[n_push[PIDX_W-1:0]] = slot_tag;
            n_push = n_push + SUM_W'(1);
          end
        end
      end
    end
  end

  // Free-port presentation: the oldest FREE_PORTS entries, valid by occupancy.
  always_comb begin
    OUT_freeValid = '0;
    OUT_freeTag   = '0;
    for (int i = 0; i < FREE_PORTS; i++) begin
      OUT_freeValid[i]                    = (count_q > CNT_W'(i));
      OUT_freeTag[i*TAG_LEN +: TAG_LEN]   = mem_q[rd_ptr_q + PTR_W'(i)];
    end
  end

  // Stall leaves room for one full bundle based on registered occupancy only.
  assign OUT_stall     = (count_q > CNT_W'(FREE_DEPTH - WIDTH));
  assign OUT_lookupTag = lookup_q;
  assign OUT_overflow  = overflow_q;

  // Pop/push accounting; pushes beyond capacity are dropped youngest-first.
  always_comb begin
    n_pop = '0;
    for (int i = 0; i < FREE_PORTS; i++) begin
      if (OUT_freeValid[i] && IN_freeReady[i]) begin
        n_pop = n_pop + SUM_W'(1);
      end
    end
    room       = SUM_W'(FREE_DEPTH) - SUM_W'(count_q) + n_pop;
    overflow_d = overflow_q;
    if (n_push > room) begin
      n_accept   = room;
      overflow_d = 1'b1;
    end else begin
      n_accept   = n_push;
    end
    count_d  = CNT_W'(SUM_W'(count_q) + n_accept - n_pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_accept);
  end

  // Table, FIFO control and lookup register; reset restores the identity map.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NUM_AREGS; a++) begin
        crat_q[a] <= (a == 0) ? NO_TAG : TAG_LEN'(a);
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      lookup_q   <= NO_TAG;
    end else begin
      for (int a = 0; a < NUM_AREGS; a++) begin
        crat_q[a] <= crat_d[a];
      end
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      // Reads the table as held before this cycle's commits land.
      lookup_q   <= crat_q[IN_lookupRd];
    end
  end

  // FIFO storage write of the accepted pushes, packed in slot order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (SUM_W'(k) < n_accept) begin
          mem_q[wr_ptr_q + PTR_W'(k)] <= push_tag[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_rat.sv
// Self-checking bench for commit_rat: directed scenarios then randomized traffic.
// Reference keeps the table as an int array and the free list as a queue.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_commit_rat;
  localparam int W  = 4;
  localparam int TL = 7;
  localparam int FD = 16;
  localparam int FP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      com_valid;
  logic [W*5-1:0]    com_rd;
  logic [W*TL-1:0]   com_tag;
  logic              flush;
  logic              stall;
  logic [FP-1:0]     free_valid;
  logic [FP*TL-1:0]  free_tag;
  logic [FP-1:0]     free_ready;
  logic [4:0]        lookup_rd;
  logic [TL-1:0]     lookup_tag;
  logic              overflow;

  int errors = 0;
  int checks = 0;

  // Reference state
  int crat_m [32];
  int fq [$];
  bit ovf_m;
  int exp_lookup;

  always #5 clk = ~clk;

  commit_rat #(.WIDTH(W), .NUM_AREGS(32), .TAG_LEN(TL), .FREE_DEPTH(FD), .FREE_PORTS(FP)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_comValid  (com_valid),
    .IN_comRd     (com_rd),
    .IN_comTag    (com_tag),
    .IN_flush     (flush),
    .OUT_stall    (stall),
    .OUT_freeValid(free_valid),
    .OUT_freeTag  (free_tag),
    .IN_freeReady (free_ready),
    .IN_lookupRd  (lookup_rd),
    .OUT_lookupTag(lookup_tag),
    .OUT_overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_slots();
    com_valid = '0;
    com_rd    = '0;
    com_tag   = '0;
  endtask

  task automatic set_slot(input int s, input int rd, input int tg);
    com_valid[s]        = 1'b1;
    com_rd[s*5 +: 5]    = 5'(rd);
    com_tag[s*TL +: TL] = TL'(tg);
  endtask

  // Apply the architectural rules to the reference for the inputs now driven.
  task automatic model_step();
    int pl [$];
    int npop;
    int rd;
    int tg;
    int old;
    if (rst) begin
      crat_m[0] = 64;
      for (int i = 1; i < 32; i++) crat_m[i] = i;
      fq.delete();
      ovf_m      = 1'b0;
      exp_lookup = 64;
      return;
    end
    exp_lookup = crat_m[lookup_rd];
    if (!flush) begin
      for (int s = 0; s < W; s++) begin
        if (com_valid[s]) begin
          rd = int'(com_rd[s*5 +: 5]);
          tg = int'(com_tag[s*TL +: TL]);
          if (rd != 0) begin
            old = crat_m[rd];
            crat_m[rd] = tg;
            if (old < 64) pl.push_back(old);
          end else if (tg < 64) begin
            pl.push_back(tg);
          end
        end
      end
    end
    npop = 0;
    while (npop < FP && npop < fq.size() && free_ready[npop]) npop++;
    repeat (npop) void'(fq.pop_front());
    foreach (pl[k]) begin
      if (fq.size() < FD) fq.push_back(pl[k]);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < FP; p++) begin
      check("free_vld", 32'(free_valid[p]), 32'(fq.size() > p));
      if (fq.size() > p) check("free_tag", 32'(free_tag[p*TL +: TL]), 32'(fq[p]));
    end
    check("stall", 32'(stall), 32'(fq.size() > FD - W));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("lookup", 32'(lookup_tag), 32'(exp_lookup));
  endtask

  // One clock: model consumes current inputs, DUT latches them, then compare.
  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int r;
    rst = 1'b1; flush = 1'b0; free_ready = '0; lookup_rd = 5'd0;
    clear_slots();
    tick();
    check("rst_lookup", 32'(lookup_tag), 32'h40);
    check("rst_vld", 32'(free_valid), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // Lookup of untouched register returns identity tag.
    rst = 1'b0; lookup_rd = 5'd5;
    tick();
    check("lookup5", 32'(lookup_tag), 32'h05);

    // Single commit; freed tag held stable while ready is low.
    set_slot(0, 5, 'h20);
    tick();
    clear_slots();
    repeat (3) begin
      tick();
      check("hold_tag", 32'(free_tag[TL-1:0]), 32'h05);
      check("hold_vld", 32'(free_valid), 32'h1);
    end
    check("crat5", 32'(lookup_tag), 32'h20);
    free_ready = 2'b01;
    tick();

    // Same-register chain inside one bundle.
    free_ready = '0;
    set_slot(0, 3, 'h21);
    set_slot(1, 3, 'h22);
    tick();
    clear_slots();
    check("chain_vld", 32'(free_valid), 32'h3);
    check("chain_t0", 32'(free_tag[TL-1:0]), 32'h03);
    check("chain_t1", 32'(free_tag[2*TL-1:TL]), 32'h21);
    lookup_rd = 5'd3; free_ready = 2'b11;
    tick();
    check("crat3", 32'(lookup_tag), 32'h22);

    // Give x7 a no-register mapping, drain its old tag.
    free_ready = '0;
    set_slot(0, 7, 'h45);
    tick();
    clear_slots();
    free_ready = 2'b01;
    tick();
    // x0 write returns its own tag; x7's MSB-set old tag is not freed.
    free_ready = '0;
    set_slot(0, 0, 'h23);
    set_slot(1, 7, 'h24);
    tick();
    clear_slots();
    check("x0_vld", 32'(free_valid), 32'h1);
    check("x0_tag", 32'(free_tag[TL-1:0]), 32'h23);
    lookup_rd = 5'd0; free_ready = 2'b01;
    tick();
    check("crat0", 32'(lookup_tag), 32'h40);
    lookup_rd = 5'd7;
    tick();
    check("crat7", 32'(lookup_tag), 32'h24);

    // Flush: commits ignored entirely.
    flush = 1'b1; lookup_rd = 5'd9;
    set_slot(0, 9, 'h50); set_slot(1, 9, 'h51); set_slot(2, 11, 'h52); set_slot(3, 0, 'h10);
    tick();
    clear_slots();
    flush = 1'b0;
    check("flush_vld", 32'(free_valid), 32'h0);
    tick();
    check("flush_crat9", 32'(lookup_tag), 32'h09);

    // Fill to 13 entries with ready low.
    free_ready = '0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < W; s++) set_slot(s, 10 + 4*k + s, 'h30 + 4*k + s);
      tick();
      clear_slots();
    end
    set_slot(0, 22, 'h3c);
    tick();
    clear_slots();
    check("stall13", 32'(stall), 32'h1);
    free_ready = 2'b11;
    tick();
    check("stall11", 32'(stall), 32'h0);
    // Forced pushes past capacity: 11 -> 15 -> 16 with overflow.
    free_ready = '0;
    for (int s = 0; s < W; s++) set_slot(s, 23 + s, 'h3d + s);
    tick();
    check("ovf_pre", 32'(overflow), 32'h0);
    for (int s = 0; s < W; s++) set_slot(s, 27 + s, 'h41 + s);
    tick();
    clear_slots();
    check("ovf_set", 32'(overflow), 32'h1);
    free_ready = 2'b11;
    repeat (9) tick();
    check("drained", 32'(free_valid), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);

    // Randomized traffic; commits only when the reference has room.
    for (int c = 0; c < 300; c++) begin
      clear_slots();
      lookup_rd = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 2);
      free_ready = FP'((1 << r) - 1);
      flush = ($urandom_range(0, 7) == 0);
      if (fq.size() <= FD - W) begin
        for (int s = 0; s < W; s++) begin
          if ($urandom_range(0, 1) == 1) begin
            set_slot(s, $urandom_range(0, 31),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(64, 127) : $urandom_range(0, 63));
          end
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_rat.md
Name: commit_rat

Overview:
- Committed register alias table (CRAT) that sits directly downstream of the reorder buffer's commit ports.
- Consumes up to WIDTH in-order committed uops per cycle and records each architectural register's committed physical tag.
- Returns the superseded physical tags to rename's free list through a FIFO.
- During mispredict replay the commit stream is ignored, so the table always reflects precise architectural state. Rename reads it for recovery through a registered lookup port.

Parameters:
- WIDTH, 4, commit slots per cycle
- NUM_AREGS, 32, architectural registers (x0..x31)
- TAG_LEN, 7, physical tag width; tag MSB=1 means "no physical register" (immediate / x0 tag 7'h40)
- FREE_DEPTH, 16, free-tag FIFO entries (power of two, >= 2*WIDTH)
- FREE_PORTS, 2, tags dequeued per cycle

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_comValid  in  WIDTH  per-slot commit valid; slot 0 is oldest
- IN_comRd  in  WIDTH*5  per-slot architectural destination
- IN_comTag  in  WIDTH*TAG_LEN  per-slot new physical tag
- IN_flush  in  1  mispredict replay active; commits this cycle are not architectural
- OUT_stall  out  1  upstream must not present commits this cycle
- OUT_freeValid  out  FREE_PORTS  freed-tag valid per port
- OUT_freeTag  out  FREE_PORTS*TAG_LEN  freed tags, port 0 oldest
- IN_freeReady  in  FREE_PORTS  consumer accepts port i; must be prefix-contiguous (ready[i] implies ready[i-1])
- IN_lookupRd  in  5  architectural register to read
- OUT_lookupTag  out  TAG_LEN  committed tag of IN_lookupRd, one cycle later
- OUT_overflow  out  1  sticky error: FIFO push beyond capacity

Behaviour:
- Reset (rst=1 at posedge; overrides every other input):
  - crat[0]=7'h40; crat[i]={0,i} for i=1..31.
  - FIFO empty: rd ptr = wr ptr = count = 0.
  - OUT_overflow=0; OUT_lookupTag=7'h40.
  - Combinational outputs with an empty FIFO: OUT_freeValid=0, OUT_stall=0.
- Commit, when IN_flush=0 and not reset: slots are processed in order 0..WIDTH-1 within a single cycle.
  - rd!=0: the old tag is the current mapping, including bypass from earlier slots of the same cycle with equal rd. Write crat[rd]=tag; the youngest slot wins.
  - Old tag MSB=0: push the old tag to the FIFO.
  - rd==0 with tag MSB=0: push the new tag itself (write to x0 is discarded). crat[0] never changes.
  - At most WIDTH pushes per cycle, packed in slot order.
- Flush: IN_flush=1 means no CRAT writes and no pushes. FIFO pops and lookup continue normally.
- FIFO:
  - OUT_freeValid[i] = (count > i); OUT_freeTag[i] = mem[rdPtr+i], modulo FREE_DEPTH.
  - pops = number of i with freeValid[i] && freeReady[i].
  - Pushed tags are not visible for popping in the same cycle (no bypass).
  - count_next = count + pushes - pops.
  - Pointers are log2(FREE_DEPTH) bits and wrap naturally.
- Stall: OUT_stall = (count > FREE_DEPTH - WIDTH). This is combinational from registered count and guarantees room for a full commit bundle.
- Overflow: if count + pushes - pops > FREE_DEPTH, set OUT_overflow=1 (sticky until reset) and drop the excess pushes (youngest first). This is a protocol violation only.
- Lookup: OUT_lookupTag at cycle N+1 = crat[IN_lookupRd] as held at the start of cycle N, i.e. before cycle N's commit writes.
- Latency: a commit at cycle N is visible in crat, and its freed tag in OUT_freeValid, from cycle N+1.

Test Plan:
- Reset, then drive IN_lookupRd=5 -> OUT_lookupTag=7'h05 next cycle; OUT_freeValid=0; OUT_stall=0.
- Commit slot0 rd=5 tag=7'h20 -> next cycle crat[5]=7'h20 and freeTag[0]=7'h05 valid. Hold ready=0 for 3 cycles -> tag is held stable.
- Same-cycle commits slot0 rd=3 tag=7'h21 and slot1 rd=3 tag=7'h22 -> frees 7'h03 then 7'h21 in that order; crat[3]=7'h22.
- Commit rd=0 tag=7'h23, plus rd=7 whose old mapping is 7'h40-class (MSB=1) -> only 7'h23 is pushed; crat[0] stays 7'h40.
- IN_flush=1 with 4 valid commits -> crat unchanged and no pushes; lookup of the committed rd returns the pre-flush tag.
- Fill FIFO to 13 with ready=0 -> OUT_stall=1. Pop 2 with ready=2'b11 -> count 11 and stall drops. Forcing 4 pushes at count 15 -> OUT_overflow=1 and count=16. Verify pointers wrap correctly over 40 cycles of random traffic.
